// File: rtl/inst_cache.sv
// Direct-mapped, one-word-per-line instruction cache. Hits are answered combinationally;
// misses refill one word from the memory controller through a two-state FSM.
module inst_cache #(
    parameter int unsigned INDEX_WIDTH = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        IC_able_read,
    input  logic [31:0] IC_inst_addr,
    output logic        IC_inst_valid,
    output logic [31:0] IC_inst,
    output logic        MC_req,
    output logic [31:0] MC_addr,
    input  logic        MC_valid,
    input  logic [31:0] MC_data
);

    localparam int unsigned Lines    = 1 << INDEX_WIDTH;
    localparam int unsigned TagWidth = 30 - INDEX_WIDTH;

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e                 state_q, state_d;
    logic                   mc_req_q, mc_req_d;
    logic [31:0]            mc_addr_q, mc_addr_d;
    logic [INDEX_WIDTH-1:0] fill_idx_q, fill_idx_d;
    logic [TagWidth-1:0]    fill_tag_q, fill_tag_d;
    logic                   fill_we;

    logic [Lines-1:0]       valid_q;
    logic [TagWidth-1:0]    tag_arr  [Lines];
    logic [31:0]            data_arr [Lines];

    logic [INDEX_WIDTH-1:0] req_idx;
    logic [TagWidth-1:0]    req_tag;
    logic                   hit;
    logic                   unused_addr_bits;

    assign req_idx          = IC_inst_addr[INDEX_WIDTH+1:2];
    assign req_tag          = IC_inst_addr[31:INDEX_WIDTH+2];
    assign unused_addr_bits = ^IC_inst_addr[1:0];

    // Lookup always uses the live address, so a stale refill is never shown for a redirect.
    assign hit           = rdy & IC_able_read & valid_q[req_idx] & (tag_arr[req_idx] == req_tag);
    assign IC_inst_valid = hit;
    assign IC_inst       = hit ? data_arr[req_idx] : 32'h0;
    assign MC_req        = mc_req_q;
    assign MC_addr       = mc_addr_q;

    always_comb begin
        state_d    = state_q;
        mc_req_d   = mc_req_q;
        mc_addr_d  = mc_addr_q;
        fill_idx_d = fill_idx_q;
        fill_tag_d = fill_tag_q;
        fill_we    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (IC_able_read && !hit) begin
                    mc_req_d   = 1'b1;
                    mc_addr_d  = {IC_inst_addr[31:2], 2'b00};
                    fill_idx_d = req_idx;
                    fill_tag_d = req_tag;
                    state_d    = StWait;
                end else begin
                    mc_req_d = 1'b0;
                end
            end
            StWait: begin
                if (MC_valid) begin
                    fill_we  = 1'b1;
                    mc_req_d = 1'b0;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            mc_req_q   <= 1'b0;
            mc_addr_q  <= 32'h0;
            fill_idx_q <= '0;
            fill_tag_q <= '0;
            valid_q    <= '0;
        end else if (rdy) begin
            state_q    <= state_d;
            mc_req_q   <= mc_req_d;
            mc_addr_q  <= mc_addr_d;
            fill_idx_q <= fill_idx_d;
            fill_tag_q <= fill_tag_d;
            if (fill_we) begin
                valid_q[fill_idx_q] <= 1'b1;
            end
        end
    end

    // Tag/data storage carries no reset; the valid bits alone qualify it.
    always_ff @(posedge clk) begin
        if (rst && rdy && fill_we) begin
            tag_arr[fill_idx_q]  <= fill_tag_q;
            data_arr[fill_idx_q] <= MC_data;
        end
    end

endmodule

// File: tb/tb_inst_cache.sv
// Directed self-checking bench for inst_cache with hand-computed expectations.
module tb_inst_cache;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        IC_able_read;
    logic [31:0] IC_inst_addr;
    logic        IC_inst_valid;
    logic [31:0] IC_inst;
    logic        MC_req;
    logic [31:0] MC_addr;
    logic        MC_valid;
    logic [31:0] MC_data;

    int n_checks = 0;
    int n_errors = 0;

    inst_cache #(.INDEX_WIDTH(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .IC_able_read (IC_able_read),
        .IC_inst_addr (IC_inst_addr),
        .IC_inst_valid(IC_inst_valid),
        .IC_inst      (IC_inst),
        .MC_req       (MC_req),
        .MC_addr      (MC_addr),
        .MC_valid     (MC_valid),
        .MC_data      (MC_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge, then settle combinational outputs.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst          = 1'b0;
        rdy          = 1'b1;
        IC_able_read = 1'b1;
        IC_inst_addr = 32'h0;
        MC_valid     = 1'b0;
        MC_data      = 32'h0;

        // Reset held two cycles with a live request.
        step();
        step();
        check("rst_mc_req", {31'h0, MC_req}, 32'h0);
        check("rst_ic_valid", {31'h0, IC_inst_valid}, 32'h0);
        check("rst_ic_inst", IC_inst, 32'h0);
        check("rst_mc_addr", MC_addr, 32'h0);
        rst = 1'b1;
        step();
        check("first_req", {31'h0, MC_req}, 32'h1);
        check("first_addr", MC_addr, 32'h0);
        MC_valid = 1'b1;
        MC_data  = 32'h11;
        step();
        MC_valid = 1'b0;
        settle();
        check("fill0_req_drop", {31'h0, MC_req}, 32'h0);
        check("fill0_hit", {31'h0, IC_inst_valid}, 32'h1);
        check("fill0_data", IC_inst, 32'h11);

        // Cold miss at 0x4, memory answers three cycles after MC_req.
        IC_inst_addr = 32'h4;
        settle();
        check("cold_nohit", {31'h0, IC_inst_valid}, 32'h0);
        step();
        check("cold_req", {31'h0, MC_req}, 32'h1);
        check("cold_addr", MC_addr, 32'h4);
        step();
        check("cold_wait1", {31'h0, IC_inst_valid}, 32'h0);
        step();
        check("cold_wait2_req", {31'h0, MC_req}, 32'h1);
        MC_valid = 1'b1;
        MC_data  = 32'h0040_0093;
        settle();
        check("cold_no_bypass", {31'h0, IC_inst_valid}, 32'h0);
        step();
        MC_valid = 1'b0;
        settle();
        check("cold_req_drop", {31'h0, MC_req}, 32'h0);
        check("cold_hit", {31'h0, IC_inst_valid}, 32'h1);
        check("cold_data", IC_inst, 32'h0040_0093);

        // Byte offset ignored.
        IC_inst_addr = 32'h6;
        settle();
        check("off_hit", {31'h0, IC_inst_valid}, 32'h1);
        check("off_data", IC_inst, 32'h0040_0093);
        step();
        check("off_no_req", {31'h0, MC_req}, 32'h0);

        // Same-index conflict: 0x100 evicts 0x000.
        IC_inst_addr = 32'h100;
        settle();
        check("conf_miss", {31'h0, IC_inst_valid}, 32'h0);
        step();
        check("conf_req_addr", MC_addr, 32'h100);
        MC_valid = 1'b1;
        MC_data  = 32'h22;
        step();
        MC_valid = 1'b0;
        settle();
        check("conf_hit", {31'h0, IC_inst_valid}, 32'h1);
        check("conf_data", IC_inst, 32'h22);
        IC_inst_addr = 32'h0;
        settle();
        check("conf_evicted", {31'h0, IC_inst_valid}, 32'h0);
        step();
        check("conf_rereq", {31'h0, MC_req}, 32'h1);
        check("conf_rereq_addr", MC_addr, 32'h0);
        MC_valid = 1'b1;
        MC_data  = 32'h11;
        step();
        MC_valid = 1'b0;

        // Redirect during WAIT for 0x8.
        IC_inst_addr = 32'h8;
        step();
        check("redir_req_addr", MC_addr, 32'h8);
        IC_inst_addr = 32'h40;
        MC_valid     = 1'b1;
        MC_data      = 32'h33;
        settle();
        check("redir_nohit_pre", {31'h0, IC_inst_valid}, 32'h0);
        step();
        MC_valid = 1'b0;
        MC_data  = 32'h0;
        settle();
        check("redir_req_drop", {31'h0, MC_req}, 32'h0);
        check("redir_nohit_new", {31'h0, IC_inst_valid}, 32'h0);
        step();
        check("redir_new_req", {31'h0, MC_req}, 32'h1);
        check("redir_new_addr", MC_addr, 32'h40);
        MC_valid = 1'b1;
        MC_data  = 32'h44;
        step();
        MC_valid = 1'b0;
        settle();
        check("redir_new_data", IC_inst, 32'h44);
        IC_inst_addr = 32'h8;
        settle();
        check("redir_old_hit", {31'h0, IC_inst_valid}, 32'h1);
        check("redir_old_data", IC_inst, 32'h33);

        // rdy low for five cycles mid-WAIT; outputs hold and hits are masked.
        IC_inst_addr = 32'hC;
        step();
        check("stall_req_addr", MC_addr, 32'hC);
        rdy          = 1'b0;
        IC_inst_addr = 32'h4;
        for (int i = 0; i < 5; i++) begin
            settle();
            check("stall_req", {31'h0, MC_req}, 32'h1);
            check("stall_addr", MC_addr, 32'hC);
            check("stall_masked", {31'h0, IC_inst_valid}, 32'h0);
            step();
        end
        rdy          = 1'b1;
        IC_inst_addr = 32'hC;

        // Reset mid-WAIT, then a stray MC_valid.
        rst = 1'b0;
        step();
        check("rstw_req_drop", {31'h0, MC_req}, 32'h0);
        rst          = 1'b1;
        IC_able_read = 1'b0;
        MC_valid     = 1'b1;
        MC_data      = 32'h55;
        step();
        MC_valid     = 1'b0;
        settle();
        check("rstw_stray_ignored", {31'h0, MC_req}, 32'h0);
        IC_able_read = 1'b1;
        settle();
        check("rstw_line_invalid", {31'h0, IC_inst_valid}, 32'h0);
        IC_inst_addr = 32'h4;
        settle();
        check("rstw_all_invalid", {31'h0, IC_inst_valid}, 32'h0);
        IC_inst_addr = 32'hC;
        step();
        check("rstw_rereq", {31'h0, MC_req}, 32'h1);
        check("rstw_rereq_addr", MC_addr, 32'hC);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
